// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helper functions for the pipeline hazard scheduler.
// Result classes, forwarding selects and per-stage Tnew lookups live here.
package hazard_ctrl_pkg;

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] wa;
        logic [2:0] res;
    } dst_t;

    // Undefined classes 5..7 collapse to "no write" before entering the shadow pipe.
    function automatic logic [2:0] res_norm(input logic [2:0] res);
        return (res > RES_MD) ? RES_NW : res;
    endfunction

    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        logic [1:0] t;
        case (res)
            RES_ALU: t = 2'd1;
            RES_DM:  t = 2'd2;
            RES_MD:  t = 2'd1;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic opnd_hazard(input logic [4:0] ra, input logic [1:0] tuse,
                                         input dst_t e, input dst_t m);
        logic hitE, hitM;
        hitE = (e.wa == ra) && (e.res != RES_NW) && (tnew_e(e.res) > tuse);
        hitM = (m.wa == ra) && (m.res != RES_NW) && (tnew_m(m.res) > tuse);
        return (ra != 5'd0) && (tuse != TUSE_NONE) && (hitE || hitM);
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] ra, input dst_t e,
                                         input dst_t m, input dst_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != 5'd0) begin
            if (e.wa == ra && e.res == RES_PC)
                sel = FWD_E;
            else if (m.wa == ra && m.res != RES_NW && tnew_m(m.res) == 2'd0)
                sel = FWD_M;
            else if (w.wa == ra && w.res != RES_NW)
                sel = FWD_W;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] ra, input dst_t m, input dst_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != 5'd0) begin
            if (m.wa == ra && m.res != RES_NW && tnew_m(m.res) == 2'd0)
                sel = FWD_M;
            else if (w.wa == ra && w.res != RES_NW)
                sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage instruction fields into the scheduler and stall/forward controls out.
interface hazard_ctrl_if;
    logic [4:0] ra1D;
    logic [4:0] ra2D;
    logic [4:0] waD;
    logic [2:0] resD;
    logic [1:0] tuse1D;
    logic [1:0] tuse2D;
    logic       mdD;
    logic       mdstartD;
    logic       mddivD;
    logic       stall;
    logic       bubbleE;
    logic [1:0] fwd1D;
    logic [1:0] fwd2D;
    logic [1:0] fwd1E;
    logic [1:0] fwd2E;
    logic       md_busy;

    modport master (
        output ra1D, ra2D, waD, resD, tuse1D, tuse2D, mdD, mdstartD, mddivD,
        input  stall, bubbleE, fwd1D, fwd2D, fwd1E, fwd2E, md_busy
    );

    modport slave (
        input  ra1D, ra2D, waD, resD, tuse1D, tuse2D, mdD, mdstartD, mddivD,
        output stall, bubbleE, fwd1D, fwd2D, fwd1E, fwd2E, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Busy down-counter for the multi-cycle mult/div unit; a start always reloads.
module md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 4'd0;
        else if (start)
            count <= div ? DIV_LOAD : MULT_LOAD;
        else if (count != 4'd0)
            count <= count - 4'd1;
    end

    assign busy = (count != 4'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler: shadows destination/result class through E, M, W and
// derives the D-stage stall plus D/E forwarding selects from that shadow.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    dst_t       dstE, dstM, dstW;
    logic [4:0] ra1E, ra2E;
    logic       mdstartE, mddivE;
    logic       mdBusy;
    logic       stallC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dstE     <= '0;
            dstM     <= '0;
            dstW     <= '0;
            ra1E     <= 5'd0;
            ra2E     <= 5'd0;
            mdstartE <= 1'b0;
            mddivE   <= 1'b0;
        end else begin
            dstW <= dstM;
            dstM <= dstE;
            if (stallC) begin
                dstE     <= '0;
                ra1E     <= 5'd0;
                ra2E     <= 5'd0;
                mdstartE <= 1'b0;
                mddivE   <= 1'b0;
            end else begin
                dstE.wa  <= hz.waD;
                dstE.res <= res_norm(hz.resD);
                ra1E     <= hz.ra1D;
                ra2E     <= hz.ra2D;
                mdstartE <= hz.mdstartD;
                mddivE   <= hz.mddivD;
            end
        end
    end

    md_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk  (clk),
        .rst  (rst),
        .start(mdstartE),
        .div  (mddivE),
        .busy (mdBusy)
    );

    // A start still sitting in E has not loaded the counter yet, so it also blocks HI/LO users.
    always_comb begin
        stallC = opnd_hazard(hz.ra1D, hz.tuse1D, dstE, dstM)
               | opnd_hazard(hz.ra2D, hz.tuse2D, dstE, dstM)
               | (hz.mdD & (mdBusy | mdstartE));
    end

    assign hz.stall   = stallC;
    assign hz.bubbleE = stallC;
    assign hz.md_busy = mdBusy;
    assign hz.fwd1D   = fwd_d(hz.ra1D, dstE, dstM, dstW);
    assign hz.fwd2D   = fwd_d(hz.ra2D, dstE, dstM, dstW);
    assign hz.fwd1E   = fwd_e(ra1E, dstM, dstW);
    assign hz.fwd2E   = fwd_e(ra2E, dstM, dstW);
endmodule
